// File: rtl/lc3_decode.sv
// lc3_decode: LC-3 decode stage with fetch alignment and a one-entry stall hold buffer.
// Define LC3_DECODE_ILLEGAL_FLAG_EN to drive illegal_op for unassigned opcodes.
module lc3_decode #(
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          instrmem_rd,
    input  logic [DW-1:0] npc,
    input  logic [DW-1:0] instr_dout,
    input  logic          enable_decode,
    input  logic          flush,
    output logic [DW-1:0] IR,
    output logic [DW-1:0] npc_out,
    output logic [5:0]    E_Control,
    output logic [1:0]    W_Control,
    output logic          Mem_Control,
    output logic          dout_valid,
    output logic          ovf_err,
    output logic          illegal_op
);
    localparam logic EMPTY = 1'b0;
    localparam logic HELD  = 1'b1;

    logic          state_q, state_d, rd_q, valid_q, valid_d, ovf_q, ovf_d, m_q, m_d;
    logic [DW-1:0] npc_q, buf_ir_q, buf_npc_q, ir_q, npc_out_q, src_ir, src_npc;
    logic [5:0]    e_q, e_d;
    logic [1:0]    w_q, w_d, alu, pcs1;
    logic [3:0]    op;
    logic          held, load, buf_we, pc_npc, op2;

    always_comb begin
        held    = state_q == HELD;
        load    = !flush && enable_decode && (held || rd_q);
        // Capture into the buffer on a stalled arrival, or refill it while draining.
        buf_we  = !flush && rd_q && (enable_decode == held);
        state_d = flush ? EMPTY :
                  enable_decode ? ((held && rd_q) ? HELD : EMPTY) :
                  ((held || rd_q) ? HELD : EMPTY);
        valid_d = flush ? 1'b0 : enable_decode ? load : valid_q;
        ovf_d   = ovf_q | (!flush && !enable_decode && held && rd_q);
        src_ir  = held ? buf_ir_q : instr_dout;
        src_npc = held ? buf_npc_q : npc_q;
        op      = src_ir[15:12];
        alu     = (op == 4'h5) ? 2'd1 : (op == 4'h9) ? 2'd2 : 2'd0;
        op2     = (op == 4'h1 || op == 4'h5) ? ~src_ir[5] : (op == 4'h9);
        pc_npc  = op inside {4'h0, 4'h2, 4'hA, 4'hE, 4'h3, 4'hB};
        pcs1    = pc_npc ? 2'd1 : (op inside {4'h6, 4'h7}) ? 2'd2 : (op == 4'hC) ? 2'd3 : 2'd0;
        e_d     = {alu, pcs1, pc_npc, op2};
        w_d     = (op inside {4'h2, 4'h6, 4'hA}) ? 2'd1 : (op == 4'hE) ? 2'd2 : 2'd0;
        m_d     = op inside {4'hA, 4'hB};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            rd_q      <= 1'b0;
            npc_q     <= '0;
            buf_ir_q  <= '0;
            buf_npc_q <= '0;
            ir_q      <= '0;
            npc_out_q <= '0;
            e_q       <= '0;
            w_q       <= '0;
            m_q       <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= flush ? 1'b0 : instrmem_rd;
            npc_q   <= npc;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            if (buf_we) begin
                buf_ir_q  <= instr_dout;
                buf_npc_q <= npc_q;
            end
            if (load) begin
                ir_q      <= src_ir;
                npc_out_q <= src_npc;
                e_q       <= e_d;
                w_q       <= w_d;
                m_q       <= m_d;
            end
        end
    end

`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
    logic ill_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ill_q <= 1'b0;
        else if (flush) ill_q <= 1'b0;
        else if (load) ill_q <= op inside {4'h4, 4'h8, 4'hD, 4'hF};
    end

    assign illegal_op = ill_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign IR          = ir_q;
    assign npc_out     = npc_out_q;
    assign E_Control   = e_q;
    assign W_Control   = w_q;
    assign Mem_Control = m_q;
    assign dout_valid  = valid_q;
    assign ovf_err     = ovf_q;
endmodule

// File: tb/tb_lc3_decode.sv
// tb_lc3_decode: directed vectors with a queue scoreboard popped by an output monitor.
module tb_lc3_decode;
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        ill;
    } exp_t;

    logic        clock, reset, instrmem_rd, enable_decode, flush;
    logic [15:0] npc, instr_dout, IR, npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control, dout_valid, ovf_err, illegal_op, adv_s;
    exp_t        sb[$];
    exp_t        ex;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam int N = 10;
    logic [15:0] s_ir [N] = '{16'h1263, 16'h6285, 16'hB402, 16'h927F, 16'h5242,
                              16'h2205, 16'hA205, 16'hC1C0, 16'h0E01, 16'hD000};
    logic [5:0]  s_e  [N] = '{6'h00, 6'h08, 6'h06, 6'h21, 6'h11, 6'h06, 6'h06, 6'h0C, 6'h06, 6'h00};
    logic [1:0]  s_w  [N] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    logic        s_m  [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        s_il [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ILL_EN};

    lc3_decode #(.DW(16)) dut (
        .clock(clock), .reset(reset), .instrmem_rd(instrmem_rd), .npc(npc),
        .instr_dout(instr_dout), .enable_decode(enable_decode), .flush(flush),
        .IR(IR), .npc_out(npc_out), .E_Control(E_Control), .W_Control(W_Control),
        .Mem_Control(Mem_Control), .dout_valid(dout_valid), .ovf_err(ovf_err),
        .illegal_op(illegal_op)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cyc(input logic rd, input logic [15:0] pc, input logic [15:0] wd,
                       input logic en, input logic fl);
        instrmem_rd = rd;
        npc = pc;
        instr_dout = wd;
        enable_decode = en;
        flush = fl;
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] ir, input logic [15:0] pc, input logic [5:0] e,
                        input logic [1:0] w, input logic m, input logic il);
        exp_t t;
        t.ir = ir; t.npc = pc; t.e = e; t.w = w; t.m = m; t.ill = il;
        sb.push_back(t);
    endtask

    // A fresh word is presented when dout_valid is high after an edge that had enable_decode set.
    always @(posedge clock) begin
        adv_s = enable_decode;
        #1;
        if (reset && adv_s && dout_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out: IR=%h npc_out=%h, expected no output", IR, npc_out);
            end else begin
                ex = sb.pop_front();
                if ({IR, npc_out, E_Control, W_Control, Mem_Control, illegal_op} !==
                    {ex.ir, ex.npc, ex.e, ex.w, ex.m, ex.ill}) begin
                    n_bad++;
                    $display("FAIL out_%h: got IR=%h npc=%h E=%h W=%0d M=%b ill=%b, expected IR=%h npc=%h E=%h W=%0d M=%b ill=%b",
                             ex.ir, IR, npc_out, E_Control, W_Control, Mem_Control, illegal_op,
                             ex.ir, ex.npc, ex.e, ex.w, ex.m, ex.ill);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        instrmem_rd = 1'b0; npc = '0; instr_dout = '0; enable_decode = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ir", IR, 0);
        chk("rst_npc", npc_out, 0);
        chk("rst_e", E_Control, 0);
        chk("rst_w", W_Control, 0);
        chk("rst_m", Mem_Control, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_ill", illegal_op, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 1, 0);
        chk("idle_valid", dout_valid, 0);

        for (int i = 0; i <= N; i++) begin
            if (i > 0) push(s_ir[i-1], 16'h3001 + 16'(i-1), s_e[i-1], s_w[i-1], s_m[i-1], s_il[i-1]);
            cyc(i < N, 16'h3001 + 16'(i), (i > 0) ? s_ir[i-1] : 16'h0000, 1, 0);
        end
        cyc(0, 0, 0, 1, 0);
        chk("drain_valid", dout_valid, 0);

        cyc(1, 16'h3010, 0, 1, 0);
        cyc(0, 0, 16'hE005, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("stall_valid", dout_valid, 0);
        chk("stall_ir_hold", IR, 16'hD000);
        push(16'hE005, 16'h3010, 6'h06, 2'd2, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        chk("ovf_before", ovf_err, 0);
        cyc(1, 16'h3020, 0, 1, 0);
        cyc(1, 16'h3021, 16'h5020, 0, 0);
        cyc(0, 0, 16'h1000, 0, 0);
        chk("ovf_set", ovf_err, 1);
        push(16'h5020, 16'h3020, 6'h10, 2'd0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("ovf_sticky", ovf_err, 1);

        cyc(1, 16'h3030, 0, 1, 0);
        cyc(1, 16'h3031, 16'h1111, 0, 0);
        cyc(0, 0, 16'h2222, 1, 1);
        chk("flush_valid", dout_valid, 0);
        chk("flush_ir_hold", IR, 16'h5020);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("post_flush_valid", dout_valid, 0);

        cyc(1, 16'h3040, 0, 1, 0);
        push(16'h1263, 16'h3040, 6'h00, 2'd0, 0, 0);
        cyc(1, 16'h3041, 16'h1263, 1, 0);
        cyc(0, 0, 16'h2205, 0, 0);
        chk("held_valid", dout_valid, 1);
        reset = 1'b0;
        #1;
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_ir", IR, 0);
        chk("midrst_ovf", ovf_err, 0);
        @(negedge clock);
        reset = 1'b1;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("postrst_valid", dout_valid, 0);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
